// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/ack bus between fetch and imem
interface fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  modport master(output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches over a variable-latency req/ack bus and holds the word for decode
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  fetch_unit_if.master     imem,
  output logic [31:0]      instr_o,
  output logic             instr_valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  pc_inc_o,
  input  logic             advance_i,
  input  logic             next_pc_src_i,
  input  logic [XLEN-1:0]  br_target_i,
  output logic             instr_fault_o
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID, FAULT} state_t;
  state_t          state_q;
  logic [XLEN-1:0] pc_q, pc_inc, npc_d;
  logic [31:0]     instr_q;
  logic            req_q, valid_q, fault_q;
  assign pc_inc = pc_q + XLEN'(4);
  assign npc_d  = next_pc_src_i ? br_target_i : pc_inc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else
      case (state_q)
        IDLE:
          if (pc_q[1:0] != 2'b00) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else begin
            state_q <= FETCH;
            req_q   <= 1'b1;
          end
        FETCH:
          if (imem.imem_ack) begin
            instr_q <= imem.imem_rdata;
            state_q <= VALID;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        VALID:
          if (advance_i) begin
            valid_q <= 1'b0;
            // a misaligned target keeps the last good PC for fault reporting
            if (npc_d[1:0] != 2'b00) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_q    <= npc_d;
              state_q <= FETCH;
              req_q   <= 1'b1;
            end
          end
        FAULT: ;
      endcase
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr_o        = instr_q;
  assign instr_valid_o  = valid_q;
  assign pc_o           = pc_q;
  assign pc_inc_o       = pc_inc;
  assign instr_fault_o  = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a transaction-level random run of the fetch stage
module tb_fetch_unit;
  logic        clk = 1'b0, rst = 1'b0;
  logic        advance, npc_src, fault, instr_valid;
  logic [31:0] br_target, instr, pc, pc_inc;
  logic [130:0] obs, exp_v;
  int total = 0, bad = 0;
  fetch_unit_if #(.XLEN(32)) bus();
  fetch_unit dut (
    .clk(clk), .rst(rst), .imem(bus),
    .instr_o(instr), .instr_valid_o(instr_valid), .pc_o(pc), .pc_inc_o(pc_inc),
    .advance_i(advance), .next_pc_src_i(npc_src), .br_target_i(br_target),
    .instr_fault_o(fault)
  );
  always #5 clk = ~clk;
  // observed vector: {req, addr, valid, instr, pc, pc_inc, fault}
  assign obs = {bus.imem_req, bus.imem_addr, instr_valid, instr, pc, pc_inc, fault};
  task automatic clear_inputs();
    advance = 1'b0;
    npc_src = 1'b0;
    br_target = '0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1;
    exp_v = {1'b0, 32'h0, 1'b0, 32'h13, 32'h0, 32'h4, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_async obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_idle obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    exp_v = {1'b1, 32'h0, 1'b0, 32'h13, 32'h0, 32'h4, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_fetch_start obs=%h exp=%h", obs, exp_v); end
  endtask
  task automatic test_first_fetch();
    repeat (2) begin
      @(negedge clk);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL first_fetch_wait obs=%h exp=%h", obs, exp_v); end
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    exp_v = {1'b0, 32'h0, 1'b1, 32'h0050_0093, 32'h0, 32'h4, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL first_fetch_valid obs=%h exp=%h", obs, exp_v); end
  endtask
  task automatic test_sequential();
    logic [31:0] w;
    advance = 1'b1;
    npc_src = 1'b0;
    br_target = 32'h0000_0300;
    @(negedge clk);
    advance = 1'b0;
    exp_v = {1'b1, 32'h4, 1'b0, 32'h0050_0093, 32'h4, 32'h8, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL seq_fetch obs=%h exp=%h", obs, exp_v); end
    w = $urandom;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = w;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    exp_v = {1'b0, 32'h4, 1'b1, w, 32'h4, 32'h8, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL seq_valid obs=%h exp=%h", obs, exp_v); end
  endtask
  task automatic test_branch();
    logic [31:0] old;
    old = instr;
    advance = 1'b1;
    npc_src = 1'b1;
    br_target = 32'h0000_0100;
    @(negedge clk);
    advance = 1'b0;
    exp_v = {1'b1, 32'h100, 1'b0, old, 32'h100, 32'h104, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL branch_fetch obs=%h exp=%h", obs, exp_v); end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h0000_006F;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    exp_v = {1'b0, 32'h100, 1'b1, 32'h6F, 32'h100, 32'h104, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL branch_valid obs=%h exp=%h", obs, exp_v); end
  endtask
  task automatic test_fault();
    advance = 1'b1;
    npc_src = 1'b1;
    br_target = 32'h0000_0102;
    @(negedge clk);
    advance = 1'b0;
    exp_v = {1'b0, 32'h100, 1'b0, 32'h6F, 32'h100, 32'h104, 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL fault_enter obs=%h exp=%h", obs, exp_v); end
    repeat (20) begin
      advance = 1'($urandom);
      npc_src = 1'($urandom);
      br_target = $urandom & 32'hFFFF_FFFC;
      bus.imem_ack = 1'($urandom);
      bus.imem_rdata = $urandom;
      @(negedge clk);
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL fault_sticky obs=%h exp=%h", obs, exp_v); end
    end
    clear_inputs();
    rst = 1'b1;
    #1;
    exp_v = {1'b0, 32'h0, 1'b0, 32'h13, 32'h0, 32'h4, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL fault_clear obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid_fetch();
    logic [31:0] w;
    w = $urandom;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = w;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    advance = 1'b1;
    npc_src = 1'b1;
    br_target = 32'h0000_0020;
    @(negedge clk);
    advance = 1'b0;
    exp_v = {1'b1, 32'h20, 1'b0, w, 32'h20, 32'h24, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL midrst_fetch obs=%h exp=%h", obs, exp_v); end
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
    exp_v = {1'b0, 32'h0, 1'b0, 32'h13, 32'h0, 32'h4, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL midrst_abandon obs=%h exp=%h", obs, exp_v); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    exp_v = {1'b1, 32'h0, 1'b0, 32'h13, 32'h0, 32'h4, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL midrst_late_ack obs=%h exp=%h", obs, exp_v); end
  endtask
  task automatic test_wrap();
    logic [31:0] w;
    w = $urandom;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = $urandom;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    advance = 1'b1;
    npc_src = 1'b1;
    br_target = 32'hFFFF_FFFC;
    @(negedge clk);
    advance = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = w;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    exp_v = {1'b0, 32'hFFFF_FFFC, 1'b1, w, 32'hFFFF_FFFC, 32'h0, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL wrap_pcinc obs=%h exp=%h", obs, exp_v); end
    advance = 1'b1;
    npc_src = 1'b0;
    @(negedge clk);
    advance = 1'b0;
    exp_v = {1'b1, 32'h0, 1'b0, w, 32'h0, 32'h4, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL wrap_fetch obs=%h exp=%h", obs, exp_v); end
  endtask
  // transaction model: one fetch = wait N cycles, ack a word, linger in VALID, then retire to a new PC
  task automatic test_random();
    logic [31:0] m_pc, m_instr, t, npc, d;
    do_reset();
    m_pc = 32'h0;
    m_instr = 32'h13;
    for (int n = 0; n < 150; n++) begin
      exp_v = {1'b1, m_pc, 1'b0, m_instr, m_pc, m_pc + 32'd4, 1'b0};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rand_fetch n=%0d obs=%h exp=%h", n, obs, exp_v); end
      repeat ($urandom_range(0, 3)) begin
        advance = 1'($urandom);
        npc_src = 1'($urandom);
        br_target = $urandom;
        @(negedge clk);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rand_wait n=%0d obs=%h exp=%h", n, obs, exp_v); end
      end
      advance = 1'b0;
      d = $urandom;
      bus.imem_ack = 1'b1;
      bus.imem_rdata = d;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      m_instr = d;
      exp_v = {1'b0, m_pc, 1'b1, m_instr, m_pc, m_pc + 32'd4, 1'b0};
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL rand_valid n=%0d obs=%h exp=%h", n, obs, exp_v); end
      repeat ($urandom_range(0, 2)) begin
        bus.imem_ack = 1'($urandom);
        bus.imem_rdata = $urandom;
        @(negedge clk);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rand_hold n=%0d obs=%h exp=%h", n, obs, exp_v); end
      end
      bus.imem_ack = 1'b0;
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      npc_src = 1'($urandom);
      br_target = t;
      npc = npc_src ? t : m_pc + 32'd4;
      advance = 1'b1;
      @(negedge clk);
      advance = 1'b0;
      if (npc[1:0] != 2'b00) begin
        exp_v = {1'b0, m_pc, 1'b0, m_instr, m_pc, m_pc + 32'd4, 1'b1};
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rand_fault n=%0d obs=%h exp=%h", n, obs, exp_v); end
        do_reset();
        m_pc = 32'h0;
        m_instr = 32'h13;
      end else
        m_pc = npc;
    end
  endtask
  initial begin
    clear_inputs();
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_fault();
    test_reset_mid_fetch();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
